// File: rtl/vrf_pkg.sv
// Shared definitions for the masked vector register file: default geometry,
// derived widths, FSM state encoding and a zero-vector constant.
package vrf_pkg;

    localparam int unsigned DEF_ELEMS    = 4;
    localparam int unsigned DEF_ELEM_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 32;

    localparam int unsigned VR_WIDTH = DEF_ELEMS * DEF_ELEM_W;
    localparam int unsigned AW       = $clog2(DEF_NUM_REGS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } vrf_state_e;

    localparam logic [VR_WIDTH-1:0] ZERO_VEC = '0;

endpackage

// File: rtl/vrf_scoreboard.sv
// Pending-write scoreboard: one busy bit per vector register, set on issue,
// cleared on writeback (set wins on collision), entry 0 never busy.
module vrf_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned AW       = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_en,
    input  logic          i_set_v,
    input  logic [AW-1:0] i_set_idx,
    input  logic          i_clr_a_v,
    input  logic [AW-1:0] i_clr_a_idx,
    input  logic          i_clr_b_v,
    input  logic [AW-1:0] i_clr_b_idx,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic          o_busy1_c,
    output logic          o_busy2_c
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Clears first so a same-cycle issue to the same register takes precedence
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_en) begin
            if (i_clr_a_v) w_busy_nxt[i_clr_a_idx] = 1'b0;
            if (i_clr_b_v) w_busy_nxt[i_clr_b_idx] = 1'b0;
            if (i_set_v)   w_busy_nxt[i_set_idx]   = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

    assign o_busy1_c = r_busy[i_ra1];
    assign o_busy2_c = r_busy[i_ra2];

endmodule

// File: rtl/vrf_masked_sb.sv
// Vector register file with two element-masked write ports, two combinational
// read ports, pending-write scoreboard and post-reset sweep-clear.
// Optional same-cycle write forwarding is enabled by defining VRF_BYPASS_EN.
module vrf_masked_sb
    import vrf_pkg::*;
#(
    parameter  int unsigned ELEMENTS_PER_REGISTER = DEF_ELEMS,
    parameter  int unsigned ELEM_WIDTH            = DEF_ELEM_W,
    parameter  int unsigned NUM_REGS              = DEF_NUM_REGS,
    localparam int unsigned L_AW                  = $clog2(NUM_REGS),
    localparam int unsigned L_VRW                 = ELEMENTS_PER_REGISTER * ELEM_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             init_busy,
    input  logic                             we_a,
    input  logic [L_AW-1:0]                  wa_a,
    input  logic [ELEMENTS_PER_REGISTER-1:0] wmask_a,
    input  logic [L_VRW-1:0]                 wd_a,
    input  logic                             we_b,
    input  logic [L_AW-1:0]                  wa_b,
    input  logic [ELEMENTS_PER_REGISTER-1:0] wmask_b,
    input  logic [L_VRW-1:0]                 wd_b,
    input  logic [L_AW-1:0]                  a1,
    input  logic [L_AW-1:0]                  a2,
    output logic [L_VRW-1:0]                 rd1,
    output logic [L_VRW-1:0]                 rd2,
    input  logic                             issue_v,
    input  logic [L_AW-1:0]                  issue_rd,
    output logic                             busy1,
    output logic                             busy2
);

    localparam int unsigned EW = ELEM_WIDTH;

    vrf_state_e r_state;
    vrf_state_e w_state_nxt;
    logic [L_AW-1:0] r_idx;
    logic [L_AW-1:0] w_idx_nxt;
    logic            r_init_busy;
    logic            w_init_busy_nxt;

    logic [L_VRW-1:0] r_mem [NUM_REGS];

    logic                             w_run;
    logic [ELEMENTS_PER_REGISTER-1:0] w_wr_a;
    logic [ELEMENTS_PER_REGISTER-1:0] w_wr_b;
    logic                             w_sb_busy1;
    logic                             w_sb_busy2;

    assign w_run  = (r_state == ST_RUN);
    assign w_wr_a = (w_run && we_a && (wa_a != '0)) ? wmask_a : '0;
    assign w_wr_b = (w_run && we_b && (wa_b != '0)) ? wmask_b : '0;

    // Sweep sequencer: one register zeroed per cycle, then normal operation
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_INIT: begin
                w_idx_nxt = r_idx + L_AW'(1);
                if (r_idx == L_AW'(NUM_REGS - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = '0;
                end
            end
            ST_RUN:  ;
            default: begin
                w_state_nxt = ST_INIT;
                w_idx_nxt   = '0;
            end
        endcase
        w_init_busy_nxt = (w_state_nxt == ST_INIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_idx       <= '0;
            r_init_busy <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_init_busy <= w_init_busy_nxt;
        end
    end

    assign init_busy = r_init_busy;

    // Port B is applied before port A so A wins on an overlapping element
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_mem[r_idx] <= '0;
            end else begin
                for (int e = 0; e < int'(ELEMENTS_PER_REGISTER); e++) begin
                    if (w_wr_b[e]) r_mem[wa_b][e*EW +: EW] <= wd_b[e*EW +: EW];
                    if (w_wr_a[e]) r_mem[wa_a][e*EW +: EW] <= wd_a[e*EW +: EW];
                end
            end
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (w_run && (a1 != '0)) rd1 = r_mem[a1];
        if (w_run && (a2 != '0)) rd2 = r_mem[a2];
`ifdef VRF_BYPASS_EN
        for (int e = 0; e < int'(ELEMENTS_PER_REGISTER); e++) begin
            if (w_wr_a[e] && (wa_a == a1))      rd1[e*EW +: EW] = wd_a[e*EW +: EW];
            else if (w_wr_b[e] && (wa_b == a1)) rd1[e*EW +: EW] = wd_b[e*EW +: EW];
            if (w_wr_a[e] && (wa_a == a2))      rd2[e*EW +: EW] = wd_a[e*EW +: EW];
            else if (w_wr_b[e] && (wa_b == a2)) rd2[e*EW +: EW] = wd_b[e*EW +: EW];
        end
`endif
    end

    vrf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (L_AW)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_run),
        .i_set_v     (issue_v),
        .i_set_idx   (issue_rd),
        .i_clr_a_v   (we_a),
        .i_clr_a_idx (wa_a),
        .i_clr_b_v   (we_b),
        .i_clr_b_idx (wa_b),
        .i_ra1       (a1),
        .i_ra2       (a2),
        .o_busy1_c   (w_sb_busy1),
        .o_busy2_c   (w_sb_busy2)
    );

    always_comb begin
        busy1 = w_sb_busy1 & w_run;
        busy2 = w_sb_busy2 & w_run;
`ifdef VRF_BYPASS_EN
        // A same-cycle writeback retires the register unless it is reissued now
        if (w_run && ((we_a && (wa_a == a1)) || (we_b && (wa_b == a1)))
            && !(issue_v && (issue_rd == a1))) busy1 = 1'b0;
        if (w_run && ((we_a && (wa_a == a2)) || (we_b && (wa_b == a2)))
            && !(issue_v && (issue_rd == a2))) busy2 = 1'b0;
`endif
    end

endmodule

// File: tb/tb_vrf_masked_sb.sv
// Scoreboard bench for vrf_masked_sb: stimulus queues expected read/busy
// values per cycle, a negedge monitor pops and compares them.
module tb_vrf_masked_sb;
    import vrf_pkg::*;

    localparam int unsigned E  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned N  = 32;
    localparam int unsigned VW = E * W;
    localparam int unsigned A  = 5;

`ifdef VRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [VW-1:0] V_ZERO = '0;
    localparam logic [VW-1:0] V_7A   = 128'h44444444_33333333_22222222_11111111;
    localparam logic [VW-1:0] V_FF   = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [VW-1:0] V_7B   = 128'h44444444_FFFFFFFF_22222222_FFFFFFFF;
    localparam logic [VW-1:0] V_99   = 128'h99999999_99999999_99999999_99999999;
    localparam logic [VW-1:0] V_AA   = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [VW-1:0] V_BB   = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;
    localparam logic [VW-1:0] V_9M   = 128'h99999999_BBBBBBBB_AAAAAAAA_AAAAAAAA;
    localparam logic [VW-1:0] V_INI  = 128'h00000000_00000000_00000000_AAAA5555;
    localparam logic [VW-1:0] V_DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [VW-1:0] V_12   = 128'h12345678_12345678_12345678_12345678;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          init_busy;
    logic          we_a = 1'b0, we_b = 1'b0;
    logic [A-1:0]  wa_a = '0, wa_b = '0;
    logic [E-1:0]  wmask_a = '0, wmask_b = '0;
    logic [VW-1:0] wd_a = '0, wd_b = '0;
    logic [A-1:0]  a1 = '0, a2 = '0;
    logic [VW-1:0] rd1, rd2;
    logic          issue_v = 1'b0;
    logic [A-1:0]  issue_rd = '0;
    logic          busy1, busy2;

    vrf_masked_sb #(
        .ELEMENTS_PER_REGISTER (E),
        .ELEM_WIDTH            (W),
        .NUM_REGS              (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .we_a      (we_a),
        .wa_a      (wa_a),
        .wmask_a   (wmask_a),
        .wd_a      (wd_a),
        .we_b      (we_b),
        .wa_b      (wa_b),
        .wmask_b   (wmask_b),
        .wd_b      (wd_b),
        .a1        (a1),
        .a2        (a2),
        .rd1       (rd1),
        .rd2       (rd2),
        .issue_v   (issue_v),
        .issue_rd  (issue_rd),
        .busy1     (busy1),
        .busy2     (busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [VW-1:0] rd1;
        logic          b1;
        logic [VW-1:0] rd2;
        logic          b2;
        logic          ib;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic chk = 1'b0;

    // Monitor: compare the queued expectation against outputs mid-cycle
    always @(negedge clk) begin
        exp_t x;
        if (chk) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL monitor: output presented with no expectation queued");
            end else begin
                x = q.pop_front();
                checks++;
                if (rd1 !== x.rd1) begin
                    errors++;
                    $display("FAIL %s rd1: got %h expected %h", x.name, rd1, x.rd1);
                end
                checks++;
                if (busy1 !== x.b1) begin
                    errors++;
                    $display("FAIL %s busy1: got %b expected %b", x.name, busy1, x.b1);
                end
                checks++;
                if (rd2 !== x.rd2) begin
                    errors++;
                    $display("FAIL %s rd2: got %h expected %h", x.name, rd2, x.rd2);
                end
                checks++;
                if (busy2 !== x.b2) begin
                    errors++;
                    $display("FAIL %s busy2: got %b expected %b", x.name, busy2, x.b2);
                end
                checks++;
                if (init_busy !== x.ib) begin
                    errors++;
                    $display("FAIL %s init_busy: got %b expected %b", x.name, init_busy, x.ib);
                end
            end
        end
    end

    task automatic push_exp(input string nm, input logic [VW-1:0] r1, input logic b1,
                            input logic [VW-1:0] r2, input logic b2, input logic ib);
        exp_t x;
        x.name = nm; x.rd1 = r1; x.b1 = b1; x.rd2 = r2; x.b2 = b2; x.ib = ib;
        q.push_back(x);
        chk = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic idle();
        we_a = 1'b0; wa_a = '0; wmask_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wmask_b = '0; wd_b = '0;
        a1 = '0; a2 = '0; issue_v = 1'b0; issue_rd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Sweep: writes and issues to register 5 must be discarded
        for (int k = 0; k < int'(N); k++) begin
            we_a = 1'b1; wa_a = 5'd5; wmask_a = 4'b1111; wd_a = V_INI;
            issue_v = 1'b1; issue_rd = 5'd5; a1 = 5'd5; a2 = 5'd5;
            push_exp("init", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b1);
            step();
        end
        idle(); a1 = 5'd5; a2 = 5'd5;
        push_exp("init_done", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();

        // Full then partial write to register 7
        idle(); we_a = 1'b1; wa_a = 5'd7; wmask_a = 4'b1111; wd_a = V_7A; a1 = 5'd7;
        push_exp("r7_full_same", BYP ? V_7A : V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();
        idle(); a1 = 5'd7;
        push_exp("r7_full", V_7A, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();
        idle(); we_a = 1'b1; wa_a = 5'd7; wmask_a = 4'b0101; wd_a = V_FF;
        step();
        idle(); a1 = 5'd7;
        push_exp("r7_masked", V_7B, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();

        // Dual-port collision on register 9
        idle(); we_b = 1'b1; wa_b = 5'd9; wmask_b = 4'b1111; wd_b = V_99;
        step();
        idle();
        we_a = 1'b1; wa_a = 5'd9; wmask_a = 4'b0011; wd_a = V_AA;
        we_b = 1'b1; wa_b = 5'd9; wmask_b = 4'b0110; wd_b = V_BB;
        step();
        idle(); a1 = 5'd9; a2 = 5'd7;
        push_exp("r9_merge", V_9M, 1'b0, V_7B, 1'b0, 1'b0);
        step();

        // Scoreboard on register 3
        idle(); issue_v = 1'b1; issue_rd = 5'd3; a1 = 5'd3;
        push_exp("sb_issue_same", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();
        idle(); a1 = 5'd3; a2 = 5'd3;
        push_exp("sb_set", V_ZERO, 1'b1, V_ZERO, 1'b1, 1'b0);
        step();
        idle(); we_b = 1'b1; wa_b = 5'd3; wmask_b = 4'b0000; wd_b = V_BB; a1 = 5'd3;
        push_exp("sb_wb_same", V_ZERO, BYP ? 1'b0 : 1'b1, V_ZERO, 1'b0, 1'b0);
        step();
        idle(); a1 = 5'd3;
        push_exp("sb_cleared", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();
        idle(); issue_v = 1'b1; issue_rd = 5'd3;
        we_a = 1'b1; wa_a = 5'd3; wmask_a = 4'b0000; a1 = 5'd3;
        push_exp("sb_collide_same", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();
        idle(); a1 = 5'd3; a2 = 5'd3;
        push_exp("sb_set_wins", V_ZERO, 1'b1, V_ZERO, 1'b1, 1'b0);
        step();

        // Register 0 stays zero and never busy
        idle(); we_a = 1'b1; wa_a = 5'd0; wmask_a = 4'b1111; wd_a = V_DEAD;
        we_b = 1'b1; wa_b = 5'd0; wmask_b = 4'b1111; wd_b = V_DEAD;
        issue_v = 1'b1; issue_rd = 5'd0;
        push_exp("r0_same", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();
        idle();
        push_exp("r0_after", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();

        // Same-cycle read of the register being written
        idle(); we_a = 1'b1; wa_a = 5'd4; wmask_a = 4'b1111; wd_a = V_12; a2 = 5'd4;
        push_exp("r4_same", V_ZERO, 1'b0, BYP ? V_12 : V_ZERO, 1'b0, 1'b0);
        step();
        idle(); a2 = 5'd4; a1 = 5'd3;
        push_exp("r4_next", V_ZERO, 1'b1, V_12, 1'b0, 1'b0);
        step();

        // Mid-operation reset restarts the sweep and clears everything
        idle(); reset = 1'b1;
        step();
        reset = 1'b0; a1 = 5'd7; a2 = 5'd3;
        push_exp("rst_mid", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b1);
        step();
        repeat (int'(N) - 1) step();
        a1 = 5'd7; a2 = 5'd9;
        push_exp("rst_swept", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();
        idle(); a1 = 5'd4; a2 = 5'd3;
        push_exp("rst_swept2", V_ZERO, 1'b0, V_ZERO, 1'b0, 1'b0);
        step();

        step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
